// File: rtl/dino_pkg.sv
// Shared types and constants for the dino display/scoreboard block.
package dino_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_OVER = 1'b1
    } state_t;

    localparam logic [1:0]  ROW_BLANK = 2'b00;
    localparam logic [1:0]  ROW_LOWER = 2'b01;
    localparam logic [1:0]  ROW_UPPER = 2'b10;
    localparam logic [15:0] SCORE_MAX = 16'h9999;

endpackage

// File: rtl/dino_bcd_score.sv
// Four-digit BCD score counter: ripple increment, saturates at 9999, sync clear.
module dino_bcd_score
    import dino_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_inc,
    input  logic        i_clr,
    output logic [15:0] o_score
);

    logic [15:0] r_score;
    logic [15:0] w_score_next;
    logic [3:0]  w_digit;
    logic        w_carry;

    // Carry ripples upward through the digits; a 9 rolls to 0 and passes the carry on.
    always_comb begin
        w_score_next = r_score;
        w_digit      = 4'd0;
        w_carry      = 1'b1;
        for (int d = 0; d < 4; d++) begin
            w_digit = r_score[4*d +: 4];
            if (w_carry) begin
                if (w_digit == 4'd9) begin
                    w_score_next[4*d +: 4] = 4'd0;
                end else begin
                    w_score_next[4*d +: 4] = w_digit + 4'd1;
                    w_carry                = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_score <= 16'h0000;
        end else if (i_clr) begin
            r_score <= 16'h0000;
        end else if (i_inc && (r_score != SCORE_MAX)) begin
            r_score <= w_score_next;
        end
    end

    assign o_score = r_score;

endmodule

// File: rtl/dino_display_scoreboard.sv
// Latches game frames, multiplexes them onto a 2x8 LED matrix, keeps score and
// blinks the frozen crash frame until restart.
module dino_display_scoreboard
    import dino_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_grid,
    input  logic        i_collision,
    input  logic        i_frame_tick,
    input  logic        i_restart,
    output logic [1:0]  o_led_row,
    output logic [7:0]  o_led_col,
    output logic [15:0] o_score,
    output logic        o_game_over
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [15:0]   r_frame_buf;
    logic [SW-1:0] r_scan_cnt;
    logic          r_row_sel;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_on;
    logic [1:0]    r_led_row;
    logic [7:0]    r_led_col;
    logic          r_game_over;
    logic          w_score_inc;
    logic          w_score_clr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A crash frame arriving with the collision is still shown, but never scored.
    always_comb begin
        w_state_next = r_state;
        w_score_inc  = 1'b0;
        w_score_clr  = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_score_inc = i_frame_tick && !i_collision;
                if (i_collision) begin
                    w_state_next = ST_OVER;
                end
            end
            ST_OVER: begin
                if (i_restart) begin
                    w_state_next = ST_RUN;
                    w_score_clr  = 1'b1;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_buf <= 16'h0000;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (r_state == ST_RUN) begin
            if (i_frame_tick) begin
                r_frame_buf <= i_grid;
            end
            if (i_collision) begin
                r_blink_cnt <= '0;
                r_blink_on  <= 1'b1;
            end
        end else if (i_restart) begin
            r_frame_buf <= 16'h0000;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (i_frame_tick) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink_on  <= !r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Row scan is free-running in both states.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scan_cnt <= '0;
            r_row_sel  <= 1'b0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_row_sel  <= !r_row_sel;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_led_row   <= ROW_BLANK;
            r_led_col   <= 8'h00;
            r_game_over <= 1'b0;
        end else begin
            r_led_row   <= r_blink_on ? (r_row_sel ? ROW_UPPER : ROW_LOWER) : ROW_BLANK;
            r_led_col   <= r_blink_on ? (r_row_sel ? r_frame_buf[15:8] : r_frame_buf[7:0]) : 8'h00;
            r_game_over <= (w_state_next == ST_OVER);
        end
    end

    dino_bcd_score u_score (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_score_inc),
        .i_clr   (w_score_clr),
        .o_score (o_score)
    );

    assign o_led_row   = r_led_row;
    assign o_led_col   = r_led_col;
    assign o_game_over = r_game_over;

endmodule

// File: tb/tb_dino_display_scoreboard.sv
// Directed bench for dino_display_scoreboard with a short scan and blink period.
module tb_dino_display_scoreboard;

    logic        clk;
    logic        rstN;
    logic [15:0] grid;
    logic        collision;
    logic        frameTick;
    logic        restart;
    logic [1:0]  ledRow;
    logic [7:0]  ledCol;
    logic [15:0] score;
    logic        gameOver;

    int testCount = 0;
    int failCount = 0;

    logic [7:0] upCol;
    logic [7:0] loCol;
    logic       seenUp;
    logic       seenLo;
    logic [1:0] expRow;

    dino_display_scoreboard #(
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_grid       (grid),
        .i_collision  (collision),
        .i_frame_tick (frameTick),
        .i_restart    (restart),
        .o_led_row    (ledRow),
        .o_led_col    (ledCol),
        .o_score      (score),
        .o_game_over  (gameOver)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic tick, input logic coll, input logic rst, input logic [15:0] g);
        grid      = g;
        frameTick = tick;
        collision = coll;
        restart   = rst;
        stepCycle();
        frameTick = 1'b0;
        collision = 1'b0;
        restart   = 1'b0;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        stepCycle();
        stepCycle();
        rstN = 1'b1;
    endtask

    // Runs through more than one full scan period, grabbing what each row shows.
    task automatic captureRows(output logic [7:0] up, output logic [7:0] lo, output logic sUp, output logic sLo);
        up  = 8'h00;
        lo  = 8'h00;
        sUp = 1'b0;
        sLo = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            if (ledRow == 2'b10 && !sUp) begin
                up  = ledCol;
                sUp = 1'b1;
            end
            if (ledRow == 2'b01 && !sLo) begin
                lo  = ledCol;
                sLo = 1'b1;
            end
        end
    endtask

    initial begin
        rstN      = 1'b0;
        grid      = 16'h0000;
        collision = 1'b0;
        frameTick = 1'b0;
        restart   = 1'b0;

        stepCycle();
        stepCycle();
        checkOutput("rst_row",   32'(ledRow),   32'h0);
        checkOutput("rst_col",   32'(ledCol),   32'h0);
        checkOutput("rst_score", 32'(score),    32'h0);
        checkOutput("rst_over",  32'(gameOver), 32'h0);

        rstN = 1'b1;
        stepCycle();
        checkOutput("first_row", 32'(ledRow), 32'h1);
        checkOutput("first_col", 32'(ledCol), 32'h0);

        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0100);
        checkOutput("score3",  32'(score),    32'h0003);
        checkOutput("over3",   32'(gameOver), 32'h0);
        captureRows(upCol, loCol, seenUp, seenLo);
        checkOutput("t1_seen_up", 32'(seenUp), 32'h1);
        checkOutput("t1_seen_lo", 32'(seenLo), 32'h1);
        checkOutput("t1_up_col",  32'(upCol),  32'h01);
        checkOutput("t1_lo_col",  32'(loCol),  32'h00);

        doReset();
        for (int k = 0; k < 12; k++) begin
            stepCycle();
            expRow = (((k / 4) % 2) == 1) ? 2'b10 : 2'b01;
            checkOutput($sformatf("scan_%0d", k), 32'(ledRow), 32'(expRow));
        end

        doReset();
        repeat (41) applyStimulus(1'b1, 1'b0, 1'b0, 16'h1234);
        checkOutput("score41", 32'(score), 32'h0041);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234);
        checkOutput("run_restart_score", 32'(score),    32'h0041);
        checkOutput("run_restart_over",  32'(gameOver), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0080);
        checkOutput("crash_over",  32'(gameOver), 32'h1);
        checkOutput("crash_score", 32'(score),    32'h0041);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'hFFFF);
        captureRows(upCol, loCol, seenUp, seenLo);
        checkOutput("frozen_seen_lo", 32'(seenLo), 32'h1);
        checkOutput("frozen_up_col",  32'(upCol),  32'h00);
        checkOutput("frozen_lo_col",  32'(loCol),  32'h80);
        checkOutput("frozen_score",   32'(score),  32'h0041);

        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 16'hFFFF);
        stepCycle();
        checkOutput("blink_off_row", 32'(ledRow), 32'h0);
        checkOutput("blink_off_col", 32'(ledCol), 32'h0);
        repeat (3) stepCycle();
        checkOutput("blink_off_row2", 32'(ledRow), 32'h0);
        checkOutput("blink_score",    32'(score),  32'h0041);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 16'hFFFF);
        captureRows(upCol, loCol, seenUp, seenLo);
        checkOutput("blink_on_seen_lo", 32'(seenLo), 32'h1);
        checkOutput("blink_on_up_col",  32'(upCol),  32'h00);
        checkOutput("blink_on_lo_col",  32'(loCol),  32'h80);

        applyStimulus(1'b1, 1'b0, 1'b1, 16'hFFFF);
        checkOutput("restart_over",  32'(gameOver), 32'h0);
        checkOutput("restart_score", 32'(score),    32'h0);
        stepCycle();
        checkOutput("restart_score2", 32'(score), 32'h0);
        captureRows(upCol, loCol, seenUp, seenLo);
        checkOutput("restart_seen_up", 32'(seenUp), 32'h1);
        checkOutput("restart_seen_lo", 32'(seenLo), 32'h1);
        checkOutput("restart_up_col",  32'(upCol),  32'h00);
        checkOutput("restart_lo_col",  32'(loCol),  32'h00);

        doReset();
        grid      = 16'h0000;
        frameTick = 1'b1;
        repeat (99) stepCycle();
        frameTick = 1'b0;
        checkOutput("score99", 32'(score), 32'h0099);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        checkOutput("score100", 32'(score), 32'h0100);
        frameTick = 1'b1;
        repeat (9899) stepCycle();
        frameTick = 1'b0;
        checkOutput("score9999", 32'(score), 32'h9999);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        checkOutput("score_sat", 32'(score), 32'h9999);

        applyStimulus(1'b1, 1'b1, 1'b0, 16'h00FF);
        checkOutput("over2", 32'(gameOver), 32'h1);
        captureRows(upCol, loCol, seenUp, seenLo);
        checkOutput("over2_lo_col", 32'(loCol), 32'hFF);
        for (int i = 0; i < 10; i++) begin
            if (ledRow == 2'b01) break;
            stepCycle();
        end
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("mid_rst_row",   32'(ledRow),   32'h0);
        checkOutput("mid_rst_col",   32'(ledCol),   32'h0);
        checkOutput("mid_rst_score", 32'(score),    32'h0);
        checkOutput("mid_rst_over",  32'(gameOver), 32'h0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
